uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: next generation of the team's fixed 8-bit receiver. It oversamples a single asynchronous serial line, validates the start bit, and assembles a configurable number of data bits, LSB first. Optional parity is checked and the stop bit is verified. Each frame is delivered through a one-entry valid/ready holding register with per-frame error flags. It sits between the board RX pin and any byte consumer (command parser, FIFO).

## Interface
- CLKS_PER_BIT, 16: clk cycles per bit period; even, ≥ 4.
- DATA_BITS, 8: data bits per frame; legal 5–9.
- PARITY_MODE, 0: 0 none, 1 odd, 2 even.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, asynchronous, idle high.
- rx_data  out  DATA_BITS  received word, bit 0 = first data bit on line.
- rx_valid  out  1  holding register contains an unconsumed frame.
- rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready.
- rx_frame_err  out  1  stop bit sampled low, qualified by rx_valid.
- rx_parity_err  out  1  parity mismatch, qualified by rx_valid; always 0 when PARITY_MODE=0.
- rx_break  out  1  frame error with all data bits 0, qualified by rx_valid.
- rx_overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- rx_busy  out  1  FSM not in IDLE.

## Operation
- Reset values: rx_data 0, rx_valid 0, all error flags 0, rx_overrun 0, rx_busy 0, FSM IDLE, synchronizer flops 1.
- rx_in passes through a 2-flop synchronizer (rx_s); the FSM only ever sees rx_s.
- Bit counter width is clog2(DATA_BITS). Cycle counter width is clog2(CLKS_PER_BIT).
- IDLE: rx_s==0 → START, cycle counter cleared.
- START: after CLKS_PER_BIT/2 cycles, sample rx_s.
  - 0 → DATA, counters cleared.
  - 1 → false start, back to IDLE with no output change.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After DATA_BITS samples → PARITY if PARITY_MODE≠0, else STOP.
- PARITY: after CLKS_PER_BIT cycles, sample rx_s.
  - Odd mode: error if XOR(data, parity bit) == 0.
  - Even mode: error if XOR(data, parity bit) == 1.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Frame error when the sample is 0.
  - Break when frame error and data == 0.
  - Then complete the frame and go to IDLE immediately, so a start edge arriving in the second half of the stop bit is caught.
- Frame completion (stop-sample edge):
  - If rx_valid==0, or rx_valid && rx_ready in the same cycle: load rx_data and flags, rx_valid=1.
  - Otherwise: discard the new frame, keep the held frame, set rx_overrun.
- Frames with errors are still delivered; the flags describe them.
- Handshake:
  - rx_valid && rx_ready with no completion → rx_valid=0 next cycle; rx_data and flags hold their last value.
  - rx_overrun clears on the next completed handshake. A frame completion in that same cycle does not re-set it.
- Only one stop bit is checked; extra stop bits look like idle.

## Timing
- T0 = first rising edge at which rx_in is low (captured by sync stage 1).
- FSM enters START at edge T0+2.
- rx_valid rises at edge T0 + 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT, where P = 1 if parity enabled, else 0.
  - For 16/8/none this is T0+154.
- rx_valid, rx_data and flags change only on completion or handshake edges; all outputs are registered.
- rx_ready → rx_valid deassert latency is 1 cycle. Back-to-back frames need no idle gap beyond half a stop bit.
- Reset asserted mid-frame:
  - Immediate return to reset values; the partial frame is lost.
  - After release, a line that is still low (mid-frame) must start a new START check, not resume the old frame.
- Glitch low shorter than CLKS_PER_BIT/2 − 2 cycles → false start, no output.

## Test plan
- 16/8/none, send 0xA5 with good stop, rx_ready=1 → rx_valid pulses 1 cycle at T0+154, rx_data=0xA5, all flags 0.
- PARITY_MODE=2, send 0x07 with parity bit 0 → rx_data=0x07, rx_parity_err=1; resend with parity 1 → rx_parity_err=0.
- Send 0x00 with stop bit low → rx_data=0x00, rx_frame_err=1, rx_break=1; send 0x10 with stop low → frame_err=1, break=0.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, rx_overrun=1. Raise rx_ready → handshake, rx_valid=0, rx_overrun=0.
- Pulse rx_in low for 4 cycles → rx_busy=1 briefly, returns to IDLE, no rx_valid.
- Assert rst_n low mid-DATA of 0x5A, release, then send 0x3C → only 0x3C is delivered, all flags clear.

Source files
------------

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver. The asynchronous serial line is synchronised and
// then sampled in the middle of each bit. Frames are LSB first, with an
// optional parity bit and one stop bit. Each finished frame goes into a
// one-entry valid/ready holding register, together with its error flags.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per bit period (even, >= 4)
//   DATA_BITS    : data bits per frame (5..9)
//   PARITY_MODE  : 0 none, 1 odd, 2 even
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   rx_in         in   serial line, idle high, asynchronous
//   rx_data       out  received word, bit 0 = first data bit on the line
//   rx_valid      out  holding register contains an unconsumed frame
//   rx_ready      in   consumer accepts; transfer when rx_valid && rx_ready
//   rx_frame_err  out  stop bit sampled low (qualified by rx_valid)
//   rx_parity_err out  parity mismatch (qualified by rx_valid)
//   rx_break      out  frame error with all data bits zero (qualified by rx_valid)
//   rx_overrun    out  sticky: a finished frame was dropped, holding register full
//   rx_busy       out  receive FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser; the FSM only ever looks at rx_s_q.
  logic sync1_q;
  logic rx_s_q;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_err_q, par_err_d;
  logic                  complete;

  // Holding register and status outputs
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  brk_q, brk_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic, bit timing and data assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    complete  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        // Mid-start-bit check; a line that is high again was just a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_err_d = 1'b0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // Shift in at the top so the first bit ends up in bit 0.
          shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          // Odd parity expects an overall XOR of 1, even parity expects 0.
          if (PARITY_MODE == 1) par_err_d = ~(^shreg_q ^ rx_s_q);
          else                  par_err_d =  (^shreg_q ^ rx_s_q);
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        // Return to idle at mid-stop so an early next start edge is not missed.
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: holding register / flag updates
  // ---------------------------------------------------------------------------
  logic hs;
  logic ferr_new;
  logic brk_new;
  logic perr_new;

  always_comb begin
    hs       = valid_q & rx_ready;
    ferr_new = ~rx_s_q;
    brk_new  = ferr_new & (shreg_q == '0);
    perr_new = (PARITY_MODE != 0) ? par_err_q : 1'b0;

    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != S_IDLE);

    // Handshake empties the register and clears the sticky overrun.
    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    // A frame finishing in the same cycle as a handshake takes the freed slot.
    if (complete) begin
      if (!valid_q || hs) begin
        data_d  = shreg_q;
        ferr_d  = ferr_new;
        perr_d  = perr_new;
        brk_d   = brk_new;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_break      = brk_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: no parity; DUT B: even parity
  logic       rx_a = 1'b1, ready_a = 1'b0;
  logic [7:0] data_a;
  logic       valid_a, ferr_a, perr_a, brk_a, ovr_a, busy_a;

  logic       rx_b = 1'b1, ready_b = 1'b0;
  logic [7:0] data_b;
  logic       valid_b, ferr_b, perr_b, brk_b, ovr_b, busy_b;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_break(brk_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_break(brk_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the selected line at v for one bit period (called at a negedge).
  task automatic drive(input logic sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity, stop, then two idle bits.
  task automatic send(input logic sel, input logic [7:0] data, input logic use_par,
                      input logic par, input logic stop);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, data[i]);
    if (use_par) drive(sel, par);
    drive(sel, stop);
    drive(sel, 1'b1);
    drive(sel, 1'b1);
    $display("frame line=%s data=%02h par=%0b/%0b stop=%0b", sel ? "B" : "A",
             data, use_par, par, stop);
  endtask

  task automatic handshake(input logic sel);
    if (sel) ready_b = 1'b1;
    else     ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    logic [9:0] frame;
    int         first_k;
    int         high_cnt;
    logic [7:0] cap_data;
    logic [2:0] cap_flags;
    logic       cap_ovr;
    logic       saw_busy;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(valid_a), 16'h0);
    check("rst_data",  16'(data_a),  16'h0);
    check("rst_flags", 16'({ferr_a, perr_a, brk_a, ovr_a}), 16'h0);
    check("rst_busy",  16'(busy_a),  16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- 0xA5, exact timing, rx_ready held high ----------------
    ready_a  = 1'b1;
    frame    = {1'b1, 8'hA5, 1'b0};
    first_k  = -1;
    high_cnt = 0;
    cap_data = 8'h00;
    cap_flags = 3'b111;
    cap_ovr  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rx_a = ((k / CPB) > 9) ? 1'b1 : frame[k / CPB];
      @(negedge clk);   // edge T0+k has just passed
      if (k == 1) check("busy_T0+1", 16'(busy_a), 16'h0);
      if (k == 2) check("busy_T0+2", 16'(busy_a), 16'h1);
      if (valid_a) begin
        if (first_k < 0) begin
          first_k   = k;
          cap_data  = data_a;
          cap_flags = {ferr_a, perr_a, brk_a};
          cap_ovr   = ovr_a;
        end
        high_cnt++;
      end
    end
    ready_a = 1'b0;
    $display("frame line=A data=a5 timed, valid at T0+%0d", first_k);
    check("a5_valid_edge", 16'(first_k),  16'd154);
    check("a5_valid_len",  16'(high_cnt), 16'd1);
    check("a5_data",       16'(cap_data), 16'h00A5);
    check("a5_flags",      16'(cap_flags), 16'h0);
    check("a5_overrun",    16'(cap_ovr),  16'h0);
    check("a5_idle_busy",  16'(busy_a),   16'h0);

    // ---------------- even parity on DUT B ----------------
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);   // three ones + parity 0 -> odd count
    check("par0_valid", 16'(valid_b), 16'h1);
    check("par0_data",  16'(data_b),  16'h0007);
    check("par0_flags", 16'({ferr_b, perr_b, brk_b, ovr_b}), 16'b0100);
    handshake(1'b1);
    check("par0_hs_valid", 16'(valid_b), 16'h0);
    check("par0_hs_data",  16'(data_b),  16'h0007);
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);   // parity 1 -> even count
    check("par1_valid", 16'(valid_b), 16'h1);
    check("par1_data",  16'(data_b),  16'h0007);
    check("par1_flags", 16'({ferr_b, perr_b, brk_b, ovr_b}), 16'h0);
    handshake(1'b1);
    check("par1_hs_busy", 16'({valid_b, busy_b}), 16'h0);

    // ---------------- frame error / break ----------------
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("brk_valid", 16'(valid_a), 16'h1);
    check("brk_data",  16'(data_a),  16'h0000);
    check("brk_flags", 16'({ferr_a, perr_a, brk_a}), 16'b101);
    handshake(1'b0);
    send(1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    check("ferr_valid", 16'(valid_a), 16'h1);
    check("ferr_data",  16'(data_a),  16'h0010);
    check("ferr_flags", 16'({ferr_a, perr_a, brk_a}), 16'b100);
    handshake(1'b0);

    // ---------------- overrun ----------------
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_valid", 16'(valid_a), 16'h1);
    check("ovr_data",  16'(data_a),  16'h0011);
    check("ovr_flag",  16'(ovr_a),   16'h1);
    check("ovr_errs",  16'({ferr_a, perr_a, brk_a}), 16'h0);
    handshake(1'b0);
    check("ovr_hs_valid", 16'(valid_a), 16'h0);
    check("ovr_hs_clear", 16'(ovr_a),   16'h0);

    // ---------------- 4-cycle glitch ----------------
    saw_busy = 1'b0;
    rx_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy_a;
    end
    rx_a = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy_a;
    end
    $display("glitch line=A low 4 cycles, busy seen=%0b", saw_busy);
    check("glitch_busy_seen", 16'(saw_busy), 16'h1);
    check("glitch_idle",      16'(busy_a),   16'h0);
    check("glitch_no_valid",  16'(valid_a),  16'h0);

    // ---------------- reset in the middle of 0x5A ----------------
    drive(1'b0, 1'b0);            // start
    drive(1'b0, 1'b0);            // bit0
    drive(1'b0, 1'b1);            // bit1
    rx_a = 1'b0;                  // bit2, reset lands half-way through
    repeat (CPB / 2) @(negedge clk);
    check("pre_rst_busy", 16'(busy_a), 16'h1);
    rst_n = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check("in_rst_busy",  16'(busy_a), 16'h0);
    check("in_rst_data",  16'(data_a), 16'h0000);
    drive(1'b0, 1'b1);            // bit3
    drive(1'b0, 1'b1);            // bit4
    drive(1'b0, 1'b0);            // bit5
    drive(1'b0, 1'b1);            // bit6
    drive(1'b0, 1'b0);            // bit7
    drive(1'b0, 1'b1);            // stop
    drive(1'b0, 1'b1);
    rst_n = 1'b1;
    $display("reset line=A asserted mid-frame 5a, released while idle");
    repeat (4) @(negedge clk);
    check("post_rst_a", 16'({valid_a, ferr_a, perr_a, brk_a, ovr_a, busy_a}), 16'h0);
    check("post_rst_b", 16'({valid_b, ferr_b, perr_b, brk_b, ovr_b, busy_b}), 16'h0);
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("3c_valid", 16'(valid_a), 16'h1);
    check("3c_data",  16'(data_a),  16'h003C);
    check("3c_flags", 16'({ferr_a, perr_a, brk_a, ovr_a}), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
